// File: rtl/cdc_mux_src_if.sv
// Valid/ready word input plus the held data bus, enable and ack lines
// shared between the clka launch stage and the clkb-side consumer.
interface cdc_mux_src_if #(
  parameter int DW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] data_bus;
  logic          en;
  logic          ack_b;

  // master: upstream producer together with the consumer's ack line
  modport master (
    output in_valid,
    output in_data,
    output ack_b,
    input  in_ready,
    input  data_bus,
    input  en
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  ack_b,
    output in_ready,
    output data_bus,
    output en
  );
endinterface

// File: rtl/cdc_mux_src.sv
// clka launch stage for the MUX-synchronised CDC path (4-phase req/ack).
// Optional per-phase handshake timeout: define MUX_SRC_TIMEOUT_EN.
module cdc_mux_src #(
  parameter int DW          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic             clka,
  input  logic             rst,
  cdc_mux_src_if.slave     bus,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [DW-1:0]          data_q;
  logic                   en_q, en_nxt;
  logic                   load, cnt_inc, ready_c;

  // ack_b is asynchronous to clka; only the last synchroniser stage is used
  always_ff @(posedge clka or posedge rst) begin
    if (rst) ack_sync <= '0;
    else     ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.ack_b};
  end
  assign ack_s = ack_sync[SYNC_STAGES-1];

`ifdef MUX_SRC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr;
  logic          tmo, err_set;

  // Timer restarts on every state change, so each phase gets TIMEOUT cycles
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      tmr <= '0;
      err <= 1'b0;
    end else begin
      tmr <= (state_nxt != state || state == IDLE) ? '0 : tmr + TW'(1);
      if (err_set) err <= 1'b1;
    end
  end
  assign tmo = (tmr == TW'(TIMEOUT - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT != 0);
  assign err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    en_nxt    = en_q;
    load      = 1'b0;
    cnt_inc   = 1'b0;
    ready_c   = 1'b0;
`ifdef MUX_SRC_TIMEOUT_EN
    err_set   = 1'b0;
`endif
    case (state)
      IDLE: begin
        // A stale ack from reset or the last transfer must clear first
        ready_c = ~ack_s;
        if (bus.in_valid && ready_c) begin
          load      = 1'b1;
          en_nxt    = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          en_nxt    = 1'b0;
          state_nxt = REL;
        end
`ifdef MUX_SRC_TIMEOUT_EN
        else if (tmo) begin
          en_nxt    = 1'b0;
          err_set   = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      REL: begin
        if (!ack_s) begin
          cnt_inc   = 1'b1;
          state_nxt = IDLE;
        end
`ifdef MUX_SRC_TIMEOUT_EN
        else if (tmo) begin
          err_set   = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // data_bus only moves on an accept edge, keeping it stable for the MUX sync
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      en_q     <= 1'b0;
      data_q   <= '0;
      xfer_cnt <= '0;
    end else begin
      state <= state_nxt;
      en_q  <= en_nxt;
      if (load)    data_q   <= bus.in_data;
      if (cnt_inc) xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready = ready_c & ~rst;
  assign bus.data_bus = data_q;
  assign bus.en       = en_q;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_cdc_mux_src.sv
// Directed self-checking bench for cdc_mux_src (SYNC_STAGES=2, CNT_W=2).
// Build with MUX_SRC_TIMEOUT_EN defined to also exercise the timeout path.
module tb_cdc_mux_src;

  logic       clka;
  logic       rst;
  logic       busy;
  logic [1:0] xfer_cnt;
  logic       err;
  int         num_compared;
  int         num_mismatched;

  cdc_mux_src_if #(.DW(4)) bus ();

  cdc_mux_src #(.DW(4), .SYNC_STAGES(2), .CNT_W(2), .TIMEOUT(8)) dut (
    .clka     (clka),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .xfer_cnt (xfer_cnt),
    .err      (err)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_compared++;
    if (got !== exp) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // All driving and sampling happens on the falling edge
  task automatic step(input int n);
    repeat (n) @(negedge clka);
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] data);
    bus.in_valid = valid;
    bus.in_data  = data;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    applyStimulus(1'b0, 4'h0);
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  // Consumer: waits for en, acks after ack_delay cycles, releases after en drops
  task automatic consumeWord(input string tag, input int ack_delay);
    int n;
    n = 0;
    while (bus.en !== 1'b1 && n < 50) begin step(1); n++; end
    checkOutput({tag, "_en_rise"}, bus.en, 1);
    step(ack_delay);
    bus.ack_b = 1'b1;
    n = 0;
    while (bus.en !== 1'b0 && n < 50) begin step(1); n++; end
    checkOutput({tag, "_en_fall"}, bus.en, 0);
    bus.ack_b = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin step(1); n++; end
    checkOutput({tag, "_release"}, busy, 0);
  endtask

  initial begin
    num_compared   = 0;
    num_mismatched = 0;
    bus.ack_b      = 1'b0;
    rst            = 1'b1;
    applyStimulus(1'b0, 4'h0);

    // Reset values
    step(2);
    checkOutput("rst_en", bus.en, 0);
    checkOutput("rst_data", bus.data_bus, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cnt", xfer_cnt, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_ready", bus.in_ready, 0);
    rst = 1'b0;
    step(1);
    checkOutput("idle_ready", bus.in_ready, 1);

    // Single word with ack returned by hand
    applyStimulus(1'b1, 4'hA);
    step(1);
    applyStimulus(1'b0, 4'h0);
    checkOutput("t1_data", bus.data_bus, 4'hA);
    checkOutput("t1_en", bus.en, 1);
    checkOutput("t1_busy", busy, 1);
    checkOutput("t1_ready_busy", bus.in_ready, 0);
    step(2);
    bus.ack_b = 1'b1;
    step(1);
    checkOutput("t1_en_held", bus.en, 1);
    step(2);
    checkOutput("t1_en_drop", bus.en, 0);
    checkOutput("t1_busy_rel", busy, 1);
    checkOutput("t1_data_rel", bus.data_bus, 4'hA);
    bus.ack_b = 1'b0;
    step(2);
    checkOutput("t1_busy_rel2", busy, 1);
    checkOutput("t1_cnt_rel", xfer_cnt, 0);
    step(1);
    checkOutput("t1_cnt", xfer_cnt, 1);
    checkOutput("t1_idle", busy, 0);

    // Back-pressure: second word waits for the first handshake
    applyReset();
    applyStimulus(1'b1, 4'h3);
    step(1);
    checkOutput("t2_data3", bus.data_bus, 4'h3);
    applyStimulus(1'b1, 4'h5);
    step(3);
    checkOutput("t2_hold_req", bus.data_bus, 4'h3);
    bus.ack_b = 1'b1;
    step(4);
    checkOutput("t2_hold_rel", bus.data_bus, 4'h3);
    checkOutput("t2_cnt_mid", xfer_cnt, 0);
    bus.ack_b = 1'b0;
    step(3);
    checkOutput("t2_cnt1", xfer_cnt, 1);
    checkOutput("t2_hold_idle", bus.data_bus, 4'h3);
    step(1);
    applyStimulus(1'b0, 4'h0);
    checkOutput("t2_data5", bus.data_bus, 4'h5);
    consumeWord("t2_w2", 2);
    step(1);
    checkOutput("t2_cnt2", xfer_cnt, 2);

    // Stale ack at reset exit blocks acceptance
    rst = 1'b1;
    bus.ack_b = 1'b1;
    step(2);
    rst = 1'b0;
    step(2);
    applyStimulus(1'b1, 4'h9);
    step(1);
    checkOutput("t3_ready_stale", bus.in_ready, 0);
    checkOutput("t3_busy_stale", busy, 0);
    bus.ack_b = 1'b0;
    step(1);
    checkOutput("t3_ready_1", bus.in_ready, 0);
    step(1);
    checkOutput("t3_ready_2", bus.in_ready, 1);
    step(1);
    applyStimulus(1'b0, 4'h0);
    checkOutput("t3_accept", bus.data_bus, 4'h9);
    consumeWord("t3", 1);
    step(1);
    checkOutput("t3_cnt", xfer_cnt, 1);

    // Reset mid-REQ clears asynchronously
    applyStimulus(1'b1, 4'hE);
    step(1);
    applyStimulus(1'b0, 4'h0);
    checkOutput("t4_en_pre", bus.en, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t4_en_async", bus.en, 0);
    checkOutput("t4_data_async", bus.data_bus, 0);
    checkOutput("t4_cnt_async", xfer_cnt, 0);
    checkOutput("t4_busy_async", busy, 0);
    step(1);
    rst = 1'b0;
    step(1);
    applyStimulus(1'b1, 4'h7);
    step(1);
    applyStimulus(1'b0, 4'h0);
    checkOutput("t4_data7", bus.data_bus, 4'h7);
    consumeWord("t4", 2);
    step(1);
    checkOutput("t4_cnt", xfer_cnt, 1);

    // Counter wrap with a 2-bit counter
    applyReset();
    for (int i = 0; i < 5; i++) begin
      logic [1:0] exp_cnt;
      exp_cnt = 2'(i + 1);
      applyStimulus(1'b1, 4'(i + 1));
      step(1);
      applyStimulus(1'b0, 4'h0);
      checkOutput("t5_data", bus.data_bus, 32'(i + 1));
      consumeWord("t5", 1);
      step(1);
      checkOutput("t5_cnt", xfer_cnt, exp_cnt);
    end

`ifdef MUX_SRC_TIMEOUT_EN
    // ack never returns: REQ phase times out after TIMEOUT cycles
    applyReset();
    applyStimulus(1'b1, 4'hC);
    step(1);
    applyStimulus(1'b0, 4'h0);
    checkOutput("t6_data", bus.data_bus, 4'hC);
    step(7);
    checkOutput("t6_en_before", bus.en, 1);
    checkOutput("t6_err_before", err, 0);
    step(1);
    checkOutput("t6_err", err, 1);
    checkOutput("t6_en", bus.en, 0);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_ready", bus.in_ready, 1);
    checkOutput("t6_cnt", xfer_cnt, 0);
    step(3);
    checkOutput("t6_err_sticky", err, 1);
`else
    checkOutput("err_off", err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
